pred_update_gen: RTL and testbench

Predictor-update generator sitting between the commit stage and the branch predictor's update ports. Accepts up to two resolved branches per cycle, classifies each one and detects target/direction mispredictions. Buffers the results in an in-order FIFO and replays them one per cycle as the predictor's update pulses (BTB correction and PHT/BHT direction training). It is the writer for the predictor's update interface and keeps that interface single-ported while commit stays dual-issue.

---
 rtl/pred_pkg.sv | 41 ++++
 rtl/pred_upd_fifo.sv | 57 +++++
 rtl/pred_update_gen.sv | 126 ++++++++++++
 tb/tb_pred_update_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_pkg.sv
// Shared branch-predictor types: branch classes, the predictor-update entry
// carried from commit to the predictor, and the commit-side classifier.
package pred_pkg;

  typedef enum logic [2:0] {
    BR_NOP  = 3'd0,
    BR_COND = 3'd1,
    BR_CALL = 3'd2,
    BR_RET  = 3'd3,
    BR_JMP  = 3'd4
  } br_type_t;

  typedef struct packed {
    logic [31:0] pc;
    br_type_t    br_type;
    logic        taken;
    logic [31:0] target;
    logic        mis_tgt;
    logic        mis_dir;
  } pred_upd_entry_t;

  // A not-taken branch never needs a BTB fix, whatever was predicted.
  function automatic pred_upd_entry_t classify(
    input logic [31:0] pc,
    input logic [2:0]  br_type,
    input logic        taken,
    input logic [31:0] target,
    input logic        pred_taken,
    input logic [31:0] pred_target
  );
    pred_upd_entry_t e;
    e.pc      = pc;
    e.br_type = br_type_t'(br_type);
    e.taken   = taken;
    e.target  = target;
    e.mis_dir = (taken != pred_taken);
    e.mis_tgt = taken && (!pred_taken || (target != pred_target));
    return e;
  endfunction

endpackage

// File: rtl/pred_upd_fifo.sv
// Two-write / one-read synchronous FIFO. Write port A always lands before
// port B, so a lone B write takes A's slot and order is preserved.
module pred_upd_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_a,
  input  T                       wr_data_a,
  input  logic                   wr_en_b,
  input  T                       wr_data_b,
  input  logic                   rd_en,
  output T                       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_idx_b;
  logic [AW:0]    count_q, count_d;
  logic [1:0]     wr_num;
  logic           rd_fire;

  always_comb begin
    rd_fire  = rd_en && (count_q != '0);
    wr_num   = {1'b0, wr_en_a} + {1'b0, wr_en_b};
    wr_idx_b = wr_ptr_q + AW'(wr_en_a);
    wr_ptr_d = wr_ptr_q + AW'(wr_num);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + (AW+1)'(wr_num) - (AW+1)'(rd_fire);
  end

  always_ff @(posedge clk) begin
    if (wr_en_a) mem_q[wr_ptr_q] <= wr_data_a;
    if (wr_en_b) mem_q[wr_idx_b] <= wr_data_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/pred_update_gen.sv
// Predictor-update generator: classifies two committed branches per cycle and
// replays them one per cycle to the predictor. Option macro: PRED_UPD_BYPASS_EN.
module pred_update_gen
  import pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            res_valid_0,
  input  logic            res_valid_1,
  input  logic [31:0]     res_pc_0,
  input  logic [31:0]     res_pc_1,
  input  logic [2:0]      res_type_0,
  input  logic [2:0]      res_type_1,
  input  logic            res_taken_0,
  input  logic            res_taken_1,
  input  logic [31:0]     res_target_0,
  input  logic [31:0]     res_target_1,
  input  logic            res_pred_taken_0,
  input  logic            res_pred_taken_1,
  input  logic [31:0]     res_pred_target_0,
  input  logic [31:0]     res_pred_target_1,
  output logic            res_ready,
  output logic            branch_mistaken,
  output logic [31:0]     wrong_pc,
  output logic [31:0]     right_target,
  output logic [2:0]      ins_type_w,
  output logic            update_orien_en,
  output logic [31:0]     retire_pc,
  output logic            right_orien,
  output logic [CNTW-1:0] mispred_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]      rst_sync_q;
  logic            rst_n_int;
  pred_upd_entry_t ent_0, ent_1, head, out_ent;
  logic            acc_0, acc_1, fifo_empty, out_valid;
  logic            wr_en_a, wr_en_b;
  pred_upd_entry_t wr_data_a, wr_data_b;
  logic [CW-1:0]   count;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Reset asserts immediately but releases two clocks later, on an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    ent_0 = classify(res_pc_0, res_type_0, res_taken_0, res_target_0,
                     res_pred_taken_0, res_pred_target_0);
    ent_1 = classify(res_pc_1, res_type_1, res_taken_1, res_target_1,
                     res_pred_taken_1, res_pred_target_1);
    res_ready  = (count <= CW'(DEPTH - 2));
    acc_0      = res_valid_0 && res_ready && (res_type_0 != BR_NOP);
    acc_1      = res_valid_1 && res_ready && (res_type_1 != BR_NOP);
    fifo_empty = (count == '0);
`ifdef PRED_UPD_BYPASS_EN
    // The oldest accepted entry skips an empty FIFO and drives outputs now.
    out_valid = !fifo_empty || acc_0 || acc_1;
    out_ent   = !fifo_empty ? head : (acc_0 ? ent_0 : ent_1);
    wr_en_a   = fifo_empty ? (acc_0 && acc_1) : acc_0;
    wr_data_a = fifo_empty ? ent_1 : ent_0;
    wr_en_b   = fifo_empty ? 1'b0 : acc_1;
    wr_data_b = ent_1;
`else
    out_valid = !fifo_empty;
    out_ent   = head;
    wr_en_a   = acc_0;
    wr_data_a = ent_0;
    wr_en_b   = acc_1;
    wr_data_b = ent_1;
`endif
  end

  pred_upd_fifo #(
    .DEPTH (DEPTH),
    .T     (pred_upd_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n_int),
    .wr_en_a   (wr_en_a),
    .wr_data_a (wr_data_a),
    .wr_en_b   (wr_en_b),
    .wr_data_b (wr_data_b),
    .rd_en     (!fifo_empty),
    .rd_data   (head),
    .count     (count)
  );

  // Outputs are zeroed rather than held so the predictor never sees stale data.
  always_comb begin
    branch_mistaken = 1'b0;
    wrong_pc        = '0;
    right_target    = '0;
    ins_type_w      = '0;
    update_orien_en = 1'b0;
    retire_pc       = '0;
    right_orien     = 1'b0;
    cnt_d           = cnt_q;
    if (out_valid) begin
      branch_mistaken = out_ent.mis_tgt;
      wrong_pc        = out_ent.pc;
      right_target    = out_ent.target;
      ins_type_w      = out_ent.br_type;
      update_orien_en = (out_ent.br_type == BR_COND);
      retire_pc       = out_ent.pc;
      right_orien     = out_ent.taken;
      if ((out_ent.mis_tgt || out_ent.mis_dir) && (cnt_q != '1))
        cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_pred_update_gen.sv
// Scoreboard bench for pred_update_gen: stimulus schedules expected pulses,
// a negedge monitor compares them; a CNTW=4 copy checks counter saturation.
module tb_pred_update_gen;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        res_valid_0, res_valid_1;
  logic [31:0] res_pc_0, res_pc_1, res_target_0, res_target_1;
  logic [31:0] res_pred_target_0, res_pred_target_1;
  logic [2:0]  res_type_0, res_type_1;
  logic        res_taken_0, res_taken_1, res_pred_taken_0, res_pred_taken_1;

  logic        res_ready, branch_mistaken, update_orien_en, right_orien;
  logic [31:0] wrong_pc, right_target, retire_pc, mispred_cnt;
  logic [2:0]  ins_type_w;

  logic        s_ready, s_mistaken, s_orien_en, s_orien;
  logic [31:0] s_wrong_pc, s_right_target, s_retire_pc;
  logic [2:0]  s_type;
  logic [3:0]  s_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ty;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } vec_t;

  typedef struct {
    logic [101:0] outs;
    logic         mis;
    int           sched;
  } exp_t;

  exp_t sb[$];
  int   pend[$];
  int   lastSched = -100;
  int   mcnt = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  pred_update_gen #(.DEPTH(DEPTH), .CNTW(32)) dut (
    .clk(clk), .resetn(resetn),
    .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
    .res_pc_0(res_pc_0), .res_pc_1(res_pc_1),
    .res_type_0(res_type_0), .res_type_1(res_type_1),
    .res_taken_0(res_taken_0), .res_taken_1(res_taken_1),
    .res_target_0(res_target_0), .res_target_1(res_target_1),
    .res_pred_taken_0(res_pred_taken_0), .res_pred_taken_1(res_pred_taken_1),
    .res_pred_target_0(res_pred_target_0), .res_pred_target_1(res_pred_target_1),
    .res_ready(res_ready), .branch_mistaken(branch_mistaken),
    .wrong_pc(wrong_pc), .right_target(right_target), .ins_type_w(ins_type_w),
    .update_orien_en(update_orien_en), .retire_pc(retire_pc),
    .right_orien(right_orien), .mispred_cnt(mispred_cnt)
  );

  pred_update_gen #(.DEPTH(DEPTH), .CNTW(4)) dutSat (
    .clk(clk), .resetn(resetn),
    .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
    .res_pc_0(res_pc_0), .res_pc_1(res_pc_1),
    .res_type_0(res_type_0), .res_type_1(res_type_1),
    .res_taken_0(res_taken_0), .res_taken_1(res_taken_1),
    .res_target_0(res_target_0), .res_target_1(res_target_1),
    .res_pred_taken_0(res_pred_taken_0), .res_pred_taken_1(res_pred_taken_1),
    .res_pred_target_0(res_pred_target_0), .res_pred_target_1(res_pred_target_1),
    .res_ready(s_ready), .branch_mistaken(s_mistaken),
    .wrong_pc(s_wrong_pc), .right_target(s_right_target), .ins_type_w(s_type),
    .update_orien_en(s_orien_en), .retire_pc(s_retire_pc),
    .right_orien(s_orien), .mispred_cnt(s_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t makeExp(input vec_t v, input int s);
    exp_t e;
    logic misDir, misTgt;
    misDir  = (v.taken != v.pred_taken);
    misTgt  = v.taken && (!v.pred_taken || (v.target != v.pred_target));
    e.outs  = {misTgt, v.pc, v.target, v.ty, (v.ty == 3'd1), v.pc, v.taken};
    e.mis   = misDir || misTgt;
    e.sched = s;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [101:0] act, input logic [101:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Monitor: one expected pulse or an all-zero output word per cycle.
  task automatic checkOutput();
    logic [101:0] act;
    exp_t e;
    act = {branch_mistaken, wrong_pc, right_target, ins_type_w,
           update_orien_en, retire_pc, right_orien};
    checkVal("mispred_cnt", 102'(mispred_cnt), 102'(mcnt));
    checkVal("mispred_cnt_w4", 102'(s_cnt), 102'((mcnt > 15) ? 15 : mcnt));
    if (sb.size() > 0 && sb[0].sched <= cyc) begin
      e = sb.pop_front();
      checkVal("update_pulse", act, e.outs);
      if (e.mis) mcnt++;
    end else begin
      checkVal("idle_outputs", act, '0);
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic scheduleEntry(input vec_t v, input int n);
    int s;
`ifdef PRED_UPD_BYPASS_EN
    s = (lastSched < n) ? n : lastSched + 1;
`else
    s = (lastSched + 1 > n + 1) ? lastSched + 1 : n + 1;
`endif
    lastSched = s;
    pend.push_back(s);
    sb.push_back(makeExp(v, s));
  endtask

  // Called #1 after a posedge; returns whether the pair was accepted.
  task automatic applyStimulus(input logic v0, input vec_t a, input logic v1,
                               input vec_t b, output logic acc);
    int   n;
    logic rdy;
    n = cyc;
    while (pend.size() > 0 && pend[0] < n) void'(pend.pop_front());
    rdy = ((DEPTH - pend.size()) >= 2);
    checkVal("res_ready", 102'(res_ready), 102'(rdy));
    res_valid_0 = v0; res_pc_0 = a.pc; res_type_0 = a.ty; res_taken_0 = a.taken;
    res_target_0 = a.target; res_pred_taken_0 = a.pred_taken; res_pred_target_0 = a.pred_target;
    res_valid_1 = v1; res_pc_1 = b.pc; res_type_1 = b.ty; res_taken_1 = b.taken;
    res_target_1 = b.target; res_pred_taken_1 = b.pred_taken; res_pred_target_1 = b.pred_target;
    acc = rdy;
    if (rdy) begin
      if (v0 && a.ty != 3'd0) scheduleEntry(a, n);
      if (v1 && b.ty != 3'd0) scheduleEntry(b, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    res_valid_0 = 1'b0;
    res_valid_1 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t fillVec(input int i);
    vec_t v;
    v.pc          = 32'h1c00_1000 + 32'(i * 4);
    v.ty          = 3'(1 + (i % 4));
    v.taken       = i[0];
    v.pred_taken  = ((i % 3) == 0);
    v.target      = 32'h1c80_0000 + 32'(i * 16);
    v.pred_target = ((i % 5) == 0) ? (v.target ^ 32'h40) : v.target;
    return v;
  endfunction

  task automatic flushModel();
    sb.delete();
    pend.delete();
    mcnt = 0;
    lastSched = -100;
  endtask

  initial begin
    vec_t a, b, z;
    logic acc;
    int   idx, guard;
    z = '{32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    res_valid_0 = 0; res_valid_1 = 0;
    res_pc_0 = 0; res_pc_1 = 0; res_type_0 = 0; res_type_1 = 0;
    res_taken_0 = 0; res_taken_1 = 0; res_target_0 = 0; res_target_1 = 0;
    res_pred_taken_0 = 0; res_pred_taken_1 = 0;
    res_pred_target_0 = 0; res_pred_target_1 = 0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_res_ready", 102'(res_ready), 102'(1));
    resetn = 1'b1;
    idle(3);

    a = '{32'h1c00_0100, 3'd1, 1'b1, 32'h1c00_0200, 1'b0, 32'h0};
    applyStimulus(1'b1, a, 1'b0, z, acc);
    idle(3);
    checkVal("cnt_after_cond", 102'(mispred_cnt), 102'(1));

    a = '{32'h1c00_0010, 3'd2, 1'b1, 32'h1c00_0080, 1'b1, 32'h1c00_0080};
    b = '{32'h1c00_0014, 3'd3, 1'b1, 32'h1c00_0040, 1'b1, 32'h0};
    applyStimulus(1'b1, a, 1'b1, b, acc);
    idle(4);
    checkVal("cnt_after_call_ret", 102'(mispred_cnt), 102'(2));

    a = '{32'h1c00_0020, 3'd0, 1'b1, 32'h1c00_0300, 1'b0, 32'h0};
    b = '{32'h1c00_0024, 3'd1, 1'b0, 32'h1c00_0100, 1'b1, 32'h1c00_0100};
    applyStimulus(1'b1, a, 1'b1, b, acc);
    idle(3);
    checkVal("cnt_after_nop_cond", 102'(mispred_cnt), 102'(3));

    idx = 0;
    guard = 0;
    while (idx < 100 && guard < 400) begin
      applyStimulus(1'b1, fillVec(idx), 1'b1, fillVec(idx + 1), acc);
      if (acc) idx += 2;
      guard++;
    end
    idle(12);
    checkVal("cnt_w4_saturated", 102'(s_cnt), 102'(4'hf));

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillVec(200 + 2 * i), 1'b1, fillVec(201 + 2 * i), acc);
    end
    res_valid_0 = 1'b0;
    res_valid_1 = 1'b0;
    resetn = 1'b0;
    flushModel();
    #1;
    checkVal("midreset_ready", 102'(res_ready), 102'(1));
    checkVal("midreset_outputs", {branch_mistaken, wrong_pc, right_target, ins_type_w,
             update_orien_en, retire_pc, right_orien}, '0);
    checkVal("midreset_cnt", 102'(mispred_cnt), 102'(0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle(3);

    a = '{32'h1c00_0400, 3'd4, 1'b1, 32'h1c00_0800, 1'b1, 32'h1c00_0900};
    applyStimulus(1'b1, a, 1'b0, z, acc);
    idle(1);

    guard = 0;
    while (sb.size() > 0 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d expected pulses never seen, required 0", sb.size());
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
